vga_frame_scanner: RTL and testbench

Parametrised VGA scan engine: generates sync/blank timing for any mode, maps each active pixel onto a framebuffer image placed at a programmable offset with integer upscaling, and issues framebuffer read addresses. It compensates for the memory's read latency so that RGB, sync and blank leave aligned. It runs in the pixel-clock domain, downstream of the PLL, and replaces the fixed 640x480 controller and video-generator pair.

---
 rtl/vga_pkg.sv | 56 +++++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_frame_scanner.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_frame_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scan engine: timing struct, default
// 640x480@60 mode, colour-bar palette and a width helper.
package vga_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  localparam int NUM_BARS = 8;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      3'd7:    return BAR_BLACK;
      default: return BAR_BLACK;
    endcase
  endfunction

  // Bits needed to hold value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised shift register with synchronous clear, used to align the
// timing flags of the scan engine with the pixel data path.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per clock; reset clears every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA scan engine: sync/blank timing, scaled framebuffer addressing and
// latency-aligned colour output. Optional colour bars: VGA_TESTPATTERN_EN.
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE    = VGA_640X480_60.h_active,
  parameter int          H_FP        = VGA_640X480_60.h_fp,
  parameter int          H_SYNC      = VGA_640X480_60.h_sync,
  parameter int          H_BP        = VGA_640X480_60.h_bp,
  parameter int          V_ACTIVE    = VGA_640X480_60.v_active,
  parameter int          V_FP        = VGA_640X480_60.v_fp,
  parameter int          V_SYNC      = VGA_640X480_60.v_sync,
  parameter int          V_BP        = VGA_640X480_60.v_bp,
  parameter int          IMAGE_W     = 400,
  parameter int          IMAGE_H     = 400,
  parameter int          X_OFF       = 0,
  parameter int          Y_OFF       = 0,
  parameter int          SCALE       = 1,
  parameter int          MEM_LATENCY = 1,
  parameter int          ADDR_W      = 19,
  parameter logic [7:0]  BORDER      = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        q,
  input  logic              test_mode,
  output logic              hsync,
  output logic              vsync,
  output logic              sync_b,
  output logic              blank_b,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [ADDR_W-1:0] address,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = clog2(H_TOTAL);
  localparam int YW      = clog2(V_TOTAL);
  localparam int SPAN_W  = IMAGE_W * SCALE;
  localparam int SPAN_H  = IMAGE_H * SCALE;
  // Flags wait 1+MEM_LATENCY stages, then share the colour output register.
  localparam int PIPE_DEPTH = 1 + MEM_LATENCY;

  localparam logic [XW-1:0]     X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [1:0]        SUB_LAST = 2'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMAGE_W);

  if (X_OFF + SPAN_W > H_ACTIVE) begin : g_bad_x
    $error("vga_frame_scanner: image exceeds active width");
  end
  if (Y_OFF + SPAN_H > V_ACTIVE) begin : g_bad_y
    $error("vga_frame_scanner: image exceeds active height");
  end
  if (longint'(IMAGE_W) * longint'(IMAGE_H) > (64'sd1 <<< ADDR_W)) begin : g_bad_addr
    $error("vga_frame_scanner: image does not fit the address space");
  end
  if (SCALE < 1 || SCALE > 4 || MEM_LATENCY < 0 || MEM_LATENCY > 4) begin : g_bad_range
    $error("vga_frame_scanner: SCALE or MEM_LATENCY out of range");
  end

  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic [ADDR_W-1:0] col_r, row_base_r;
  logic [1:0]        col_sub_r, row_sub_r;
  int                x_i_s, y_i_s, x_rel_s, y_rel_s;
  logic              active_s, x_span_s, y_span_s, inside_s;
  logic              hsync_act_s, vsync_act_s, frame_first_s;
  logic [23:0]       pixel_s;

  // Raster position: x wraps each line, y advances on that wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (x_r == X_LAST) begin
      x_r <= {XW{1'b0}};
      if (y_r == Y_LAST) y_r <= {YW{1'b0}};
      else               y_r <= y_r + YW'(1);
    end else begin
      x_r <= x_r + XW'(1);
    end
  end

  // Stage-0 decode of the raster position
  always_comb begin
    x_i_s         = int'(x_r);
    y_i_s         = int'(y_r);
    x_rel_s       = x_i_s - X_OFF;
    y_rel_s       = y_i_s - Y_OFF;
    active_s      = (x_i_s < H_ACTIVE) && (y_i_s < V_ACTIVE);
    x_span_s      = (x_rel_s >= 0) && (x_rel_s < SPAN_W);
    y_span_s      = (y_rel_s >= 0) && (y_rel_s < SPAN_H);
    inside_s      = active_s && x_span_s && y_span_s;
    hsync_act_s   = (x_i_s >= H_ACTIVE + H_FP) && (x_i_s < H_ACTIVE + H_FP + H_SYNC);
    vsync_act_s   = (y_i_s >= V_ACTIVE + V_FP) && (y_i_s < V_ACTIVE + V_FP + V_SYNC);
    frame_first_s = (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
  end

  // Stored column under the beam; each column lasts SCALE pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r     <= {ADDR_W{1'b0}};
      col_sub_r <= 2'b00;
    end else if (x_span_s) begin
      if (col_sub_r == SUB_LAST) begin
        col_sub_r <= 2'b00;
        col_r     <= col_r + ADDR_W'(1);
      end else begin
        col_sub_r <= col_sub_r + 2'b01;
      end
    end else begin
      col_r     <= {ADDR_W{1'b0}};
      col_sub_r <= 2'b00;
    end
  end

  // Row base advances by IMAGE_W once every SCALE image lines
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base_r <= {ADDR_W{1'b0}};
      row_sub_r  <= 2'b00;
    end else if (x_r == X_LAST) begin
      if (!y_span_s) begin
        row_base_r <= {ADDR_W{1'b0}};
        row_sub_r  <= 2'b00;
      end else if (row_sub_r == SUB_LAST) begin
        row_base_r <= row_base_r + ROW_STEP;
        row_sub_r  <= 2'b00;
      end else begin
        row_sub_r  <= row_sub_r + 2'b01;
      end
    end else begin
      row_base_r <= row_base_r;
      row_sub_r  <= row_sub_r;
    end
  end

  // Stage-1 framebuffer address
  always_ff @(posedge clk) begin
    if (rst)           address <= {ADDR_W{1'b0}};
    else if (inside_s) address <= row_base_r + col_r;
    else               address <= {ADDR_W{1'b0}};
  end

`ifdef VGA_TESTPATTERN_EN
  localparam int DL_W  = 9;
  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  logic [2:0] bar_idx_s;

  // Bar index by threshold compares rather than a divide of x
  always_comb begin
    bar_idx_s = 3'd0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (x_i_s >= k * BAR_W) bar_idx_s = 3'(k);
      else                    bar_idx_s = bar_idx_s;
    end
  end

  logic [DL_W-1:0] dl_d_s, dl_q_s;
  assign dl_d_s = {bar_idx_s, test_mode, frame_first_s, inside_s, active_s,
                   vsync_act_s, hsync_act_s};
`else
  localparam int DL_W = 5;
  logic [DL_W-1:0] dl_d_s, dl_q_s;
  logic            unused_test_mode_s;
  assign unused_test_mode_s = test_mode;
  assign dl_d_s = {frame_first_s, inside_s, active_s, vsync_act_s, hsync_act_s};
`endif

  // Sync polarity is stored active-high so a cleared stage means "inactive"
  vga_delay_line #(.WIDTH(DL_W), .DEPTH(PIPE_DEPTH)) u_align (
    .clk (clk),
    .rst (rst),
    .d   (dl_d_s),
    .q   (dl_q_s)
  );

  // Colour select at the stage where q is valid
  always_comb begin
    pixel_s = 24'h000000;
    if (dl_q_s[3]) begin
`ifdef VGA_TESTPATTERN_EN
      if (dl_q_s[5]) pixel_s = bar_colour(dl_q_s[8:6]);
      else           pixel_s = {q, q, q};
`else
      pixel_s = {q, q, q};
`endif
    end else if (dl_q_s[2]) begin
      pixel_s = {BORDER, BORDER, BORDER};
    end else begin
      pixel_s = 24'h000000;
    end
  end

  // Output register bank: sync, blank and colour leave together
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_b     <= 1'b0;
      frame_start <= 1'b0;
      r           <= 8'h00;
      g           <= 8'h00;
      b           <= 8'h00;
    end else begin
      hsync       <= ~dl_q_s[0];
      vsync       <= ~dl_q_s[1];
      blank_b     <= dl_q_s[2];
      frame_start <= dl_q_s[4];
      {r, g, b}   <= pixel_s;
    end
  end

  assign sync_b = 1'b0;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed self-checking bench: a tiny mode checked cycle by cycle plus three
// default-timing instances probed at hand-computed pixels.
module tb_vga_frame_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc, n_checks, n_err;

  // A: 24x12 total, 16x8 active, 8x4 image at SCALE 2 filling the active area
  logic       a_hsync, a_vsync, a_sync_b, a_blank_b, a_fs;
  logic [7:0] a_r, a_g, a_b, a_q;
  logic [4:0] a_addr;
  vga_frame_scanner #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMAGE_W(8), .IMAGE_H(4), .X_OFF(0), .Y_OFF(0), .SCALE(2),
    .MEM_LATENCY(1), .ADDR_W(5), .BORDER(8'h55)
  ) u_a (
    .clk(clk), .rst(rst_a), .q(a_q), .test_mode(1'b0),
    .hsync(a_hsync), .vsync(a_vsync), .sync_b(a_sync_b), .blank_b(a_blank_b),
    .r(a_r), .g(a_g), .b(a_b), .address(a_addr), .frame_start(a_fs)
  );
  always @(posedge clk) a_q <= {3'b000, a_addr};

  // B: default timing, 400x400 image, memory latency 2
  logic        b_hsync, b_vsync, b_sync_b, b_blank_b, b_fs;
  logic [7:0]  b_r, b_g, b_b, b_q, b_m1;
  logic [18:0] b_addr;
  vga_frame_scanner #(
    .IMAGE_W(400), .IMAGE_H(400), .X_OFF(0), .Y_OFF(0), .SCALE(1),
    .MEM_LATENCY(2), .ADDR_W(19), .BORDER(8'h11)
  ) u_b (
    .clk(clk), .rst(rst_b), .q(b_q), .test_mode(1'b0),
    .hsync(b_hsync), .vsync(b_vsync), .sync_b(b_sync_b), .blank_b(b_blank_b),
    .r(b_r), .g(b_g), .b(b_b), .address(b_addr), .frame_start(b_fs)
  );
  always @(posedge clk) begin
    b_m1 <= b_addr[7:0];
    b_q  <= b_m1;
  end

  // C: default timing, 200x200 image at (100,40), SCALE 2, latency 1
  logic        c_hsync, c_vsync, c_sync_b, c_blank_b, c_fs;
  logic [7:0]  c_r, c_g, c_b, c_q;
  logic [18:0] c_addr;
  vga_frame_scanner #(
    .IMAGE_W(200), .IMAGE_H(200), .X_OFF(100), .Y_OFF(40), .SCALE(2),
    .MEM_LATENCY(1), .ADDR_W(19), .BORDER(8'h77)
  ) u_c (
    .clk(clk), .rst(rst_b), .q(c_q), .test_mode(1'b0),
    .hsync(c_hsync), .vsync(c_vsync), .sync_b(c_sync_b), .blank_b(c_blank_b),
    .r(c_r), .g(c_g), .b(c_b), .address(c_addr), .frame_start(c_fs)
  );
  always @(posedge clk) c_q <= c_addr[7:0];

  // D: default timing, full-width single-line image, latency 0, test_mode on
  logic       d_hsync, d_vsync, d_sync_b, d_blank_b, d_fs;
  logic [7:0] d_r, d_g, d_b, d_q;
  logic [9:0] d_addr;
  vga_frame_scanner #(
    .IMAGE_W(640), .IMAGE_H(1), .X_OFF(0), .Y_OFF(0), .SCALE(1),
    .MEM_LATENCY(0), .ADDR_W(10), .BORDER(8'h20)
  ) u_d (
    .clk(clk), .rst(rst_b), .q(d_q), .test_mode(1'b1),
    .hsync(d_hsync), .vsync(d_vsync), .sync_b(d_sync_b), .blank_b(d_blank_b),
    .r(d_r), .g(d_g), .b(d_b), .address(d_addr), .frame_start(d_fs)
  );
  assign d_q = d_addr[7:0];

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    int px, py, p, t, off, a_base, b_base;
    int exp_hs, exp_vs, exp_bl, exp_r, exp_fs;
    int hs_low, vs_low, bl_high, fs_cnt;
    int rx[2];
    int ry[2];
    rx = '{10, 21};
    ry = '{5, 9};
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    hs_low = 0; vs_low = 0; bl_high = 0; fs_cnt = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a  = 1'b0;
    a_base = 0;

    check("a_sync_b", 32'(a_sync_b), 0);
    check("a_addr_rst", 32'(a_addr), 0);

    // Two full frames of the small mode, every output every cycle (L = 3)
    for (int c = 0; c < 3 + 2 * 288; c++) begin
      tick_to(c);
      if (c < 3) begin
        exp_hs = 1; exp_vs = 1; exp_bl = 0; exp_r = 0; exp_fs = 0;
      end else begin
        p  = c - 3;
        px = p % 24;
        py = (p / 24) % 12;
        exp_hs = (px >= 18 && px < 21) ? 0 : 1;
        exp_vs = (py >= 9 && py < 11) ? 0 : 1;
        exp_bl = (px < 16 && py < 8) ? 1 : 0;
        exp_r  = (exp_bl == 1) ? (py / 2) * 8 + px / 2 : 0;
        exp_fs = (px == 0 && py == 0) ? 1 : 0;
        if (a_hsync == 1'b0) hs_low++;
        if (a_vsync == 1'b0) vs_low++;
        if (a_blank_b == 1'b1) bl_high++;
        if (a_fs == 1'b1) fs_cnt++;
      end
      check("a_hsync", 32'(a_hsync), exp_hs);
      check("a_vsync", 32'(a_vsync), exp_vs);
      check("a_blank_b", 32'(a_blank_b), exp_bl);
      check("a_r", 32'(a_r), exp_r);
      check("a_gb", 32'({a_g, a_b}), (exp_r << 8) | exp_r);
      check("a_frame_start", 32'(a_fs), exp_fs);
    end
    check("a_hsync_low_total", hs_low, 72);
    check("a_vsync_low_total", vs_low, 96);
    check("a_blank_high_total", bl_high, 256);
    check("a_frame_start_total", fs_cnt, 2);

    // One-cycle reset mid-frame, first where colour is live, then inside both syncs
    for (int k = 0; k < 2; k++) begin
      off = ry[k] * 24 + rx[k];
      t   = a_base + off;
      while (t <= cyc) t += 288;
      tick_to(t);
      rst_a = 1'b1;
      tick_to(t + 1);
      check("a_rst_hsync", 32'(a_hsync), 1);
      check("a_rst_vsync", 32'(a_vsync), 1);
      check("a_rst_blank", 32'(a_blank_b), 0);
      check("a_rst_rgb", 32'({a_r, a_g, a_b}), 0);
      check("a_rst_addr", 32'(a_addr), 0);
      check("a_rst_fs", 32'(a_fs), 0);
      rst_a  = 1'b0;
      a_base = t + 1;
      tick_to(a_base + 2);
      check("a_fs_early", 32'(a_fs), 0);
      tick_to(a_base + 3);
      check("a_fs_after_rst", 32'(a_fs), 1);
      check("a_blank_after_rst", 32'(a_blank_b), 1);
    end

    // Instances B, C, D still held in reset
    check("b_rst_hsync", 32'(b_hsync), 1);
    check("b_rst_vsync", 32'(b_vsync), 1);
    check("c_rst_blank", 32'(c_blank_b), 0);
    check("c_rst_addr", 32'(c_addr), 0);
    check("d_rst_rgb", 32'({d_r, d_g, d_b}), 0);
    check("d_rst_fs", 32'(d_fs), 0);
    check("bcd_sync_b", 32'({b_sync_b, c_sync_b, d_sync_b}), 0);
    rst_b  = 1'b0;
    b_base = cyc;

    tick_to(b_base + 3);
    check("b_fs_early", 32'(b_fs), 0);
    tick_to(b_base + 4);
    check("b_fs", 32'(b_fs), 1);

`ifdef VGA_TESTPATTERN_EN
    tick_to(b_base + 7);
    check("d_bar_x5", 32'({d_r, d_g, d_b}), 32'h00FFFFFF);
    tick_to(b_base + 82);
    check("d_bar_x80", 32'({d_r, d_g, d_b}), 32'h00FFFF00);
    tick_to(b_base + 641);
    check("d_bar_x639", 32'({d_r, d_g, d_b}), 32'h00000000);
`else
    tick_to(b_base + 7);
    check("d_q_x5", 32'({d_r, d_g, d_b}), 32'h00050505);
    tick_to(b_base + 82);
    check("d_q_x80", 32'({d_r, d_g, d_b}), 32'h00505050);
    tick_to(b_base + 641);
    check("d_q_x639", 32'({d_r, d_g, d_b}), 32'h007F7F7F);
`endif
    check("d_blank_x639", 32'(d_blank_b), 1);
    tick_to(b_base + 642);
    check("d_blank_x640", 32'(d_blank_b), 0);
    tick_to(b_base + 802);
    check("d_border_y1", 32'(d_r), 32'h20);
    check("d_hv_y1", 32'({d_hsync, d_vsync, d_fs}), 32'b110);

    tick_to(b_base + 2406);
    check("b_addr_5_3", 32'(b_addr), 1205);
    tick_to(b_base + 2408);
    check("b_r_4_3", 32'(b_r), 180);
    tick_to(b_base + 2409);
    check("b_r_5_3", 32'(b_r), 181);
    check("b_gb_5_3", 32'({b_g, b_b}), 32'hB5B5);
    check("b_blank_5_3", 32'(b_blank_b), 1);
    tick_to(b_base + 2804);
    check("b_border_400_3", 32'(b_r), 32'h11);
    tick_to(b_base + 3044);
    check("b_blank_640_3", 32'({b_blank_b, b_r}), 0);

    tick_to(b_base + 32101);
    check("c_addr_100_40", 32'(c_addr), 0);
    tick_to(b_base + 32102);
    check("c_border_99_40", 32'(c_r), 32'h77);
    tick_to(b_base + 32103);
    check("c_addr_102_40", 32'(c_addr), 1);
    tick_to(b_base + 32105);
    check("c_r_102_40", 32'({c_r, c_g, c_b}), 32'h00010101);
    tick_to(b_base + 32500);
    check("c_addr_499_40", 32'(c_addr), 199);
    tick_to(b_base + 32503);
    check("c_border_500_40", 32'(c_r), 32'h77);
    tick_to(b_base + 32663);
    check("c_hsync_660_40", 32'({c_hsync, c_vsync, c_fs}), 32'b010);
    tick_to(b_base + 32902);
    check("c_addr_101_41", 32'(c_addr), 0);
    tick_to(b_base + 32904);
    check("c_addr_103_41", 32'(c_addr), 1);
    tick_to(b_base + 33701);
    check("c_addr_100_42", 32'(c_addr), 200);
    tick_to(b_base + 33703);
    check("c_addr_102_42", 32'(c_addr), 201);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
